can_param_registry: RTL and testbench
=====================================

# can_param_registry

Parametrised CAN acceptance-filter parameter registry. Loads per-filter acceptance code/mask, filter enables, SJW and a configuration lock from a byte-wide write interface into shadow registers. On `commit` it validates every filter and then updates the active outputs atomically. It sits between the host configuration path and the CAN receive filter / bit-timing logic, and supersedes the single-filter 11-bit parameter block.

## Interface
- `NUM_FILTERS`, 4, number of acceptance filters (1..8)
- `ID_W`, 11, identifier width (11 or 29)
- `ADDR_W`, 5, write address width; must satisfy G+3 <= 2^ADDR_W
- Derived, not overridable: BPI = ceil(ID_W/8) bytes per identifier; G = NUM_FILTERS*2*BPI
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  registry can accept a write
- `wr_addr`  in  ADDR_W  byte address
- `wr_data`  in  8  write byte
- `commit`  in  1  request to validate and apply shadow contents
- `busy`  out  1  commit sequence in progress
- `commit_done`  out  1  one-cycle pulse when a commit ends
- `cfg_err`  out  1  sticky: last commit was rejected
- `wr_err`  out  1  one-cycle pulse: an accepted write was dropped
- `locked`  out  1  configuration is locked
- `code_param`  out  NUM_FILTERS*ID_W  active codes; filter f at [f*ID_W +: ID_W]
- `mask_param`  out  NUM_FILTERS*ID_W  active masks; 1 = compare bit
- `filter_en`  out  NUM_FILTERS  active filter enables
- `sjw`  out  2  active synchronisation jump width

## Operation
- Address map:
  - Filter f code byte k: f*2*BPI + k.
  - Filter f mask byte k: f*2*BPI + BPI + k.
  - G+0: sjw = wr_data[1:0].
  - G+1: filter_en = wr_data[NUM_FILTERS-1:0].
  - G+2: wr_data[0] = lock request.
- Byte order is little-endian: byte k holds bits [8k+7:8k]. Bits at or above ID_W in the top byte are discarded.
- A write is accepted when `wr_valid && wr_ready`. It updates the shadow register only.
- An accepted write with address >= G+3, or any accepted write while `locked`, is dropped. `wr_err` pulses on the next cycle.
- State machine: IDLE, CHECK, APPLY.
  - IDLE: `wr_ready`=1, `busy`=0.
  - IDLE -> CHECK on `commit` when not locked. `commit` is ignored while locked or outside IDLE.
  - CHECK: index i runs 0..NUM_FILTERS-1, one filter per cycle. Filter i fails if shadow enable=1 and (code & ~mask) != 0. A disabled filter still consumes its cycle. Failures accumulate.
  - After index NUM_FILTERS-1, go to APPLY.
  - APPLY with no failure: copy all shadow values to active outputs in one cycle. Set `locked` if the shadow lock bit is 1. Clear `cfg_err`.
  - APPLY with any failure: active outputs unchanged, set `cfg_err`.
  - APPLY always pulses `commit_done` and returns to IDLE.
- Active outputs never show a partially updated configuration.
- Writes and commit in the same IDLE cycle: the write lands in shadow first and is included in that commit.
- `wr_ready`=0 in CHECK and APPLY. A held `wr_valid` waits and is not lost.
- Once `locked`=1, only `reset` clears it.

## Timing
- Reset values (shadow and active alike): code_param=0, mask_param=0, filter_en=0, sjw=2'b00, locked=0, cfg_err=0, commit_done=0, wr_err=0, busy=0. State returns to IDLE.
- With `commit` sampled in cycle t:
  - CHECK occupies t+1 .. t+NUM_FILTERS.
  - APPLY occupies t+NUM_FILTERS+1.
  - New active values, `commit_done`, the `cfg_err` update and `locked` are all visible from t+NUM_FILTERS+2.
  - `commit_done` is high for that one cycle only.
- `busy` is high from t+1 through t+NUM_FILTERS+1.
- `wr_err` is visible the cycle after the offending write.
- `reset` asserted during CHECK or APPLY aborts the commit. No `commit_done` pulse. All values reset on the next edge.

## Test plan
- Reset, then write filter0 code 0x123 (addr 0 = 0x23, addr 1 = 0x01), mask 0x7FF (addr 2 = 0xFF, addr 3 = 0x07), G+1 = 0x01, G+0 = 0x02, then commit. Expect: code_param[10:0]=0x123, mask_param[10:0]=0x7FF, filter_en=4'b0001, sjw=2, commit_done exactly 6 cycles after commit, busy high for 5 cycles.
- Check atomicity and the prior values. Write code 0x0F0 with mask 0x00F on enabled filter2, then commit. Expect: cfg_err=1, and every active output still holds its prior values.
- Fix the mask to 0x0FF and commit again. Expect: cfg_err clears and the values apply.
- Write to addr G+3 (=19). Expect: wr_err pulse and no state change.
- Hold wr_valid during a commit. Expect: wr_ready=0 through APPLY, then the write is accepted in the first IDLE cycle.
- Write G+2 = 0x01 and commit. Expect: locked=1. Then a write to addr 0 gives a wr_err pulse, a subsequent commit produces no busy or commit_done, and reset returns locked to 0.
- Assert reset 2 cycles after commit. Expect: no commit_done pulse and all outputs zero.
- Rerun with ID_W=29 (BPI=4): write code bytes 0xFF,0xFF,0xFF,0xFF. Expect code = 0x1FFFFFFF.

Source files
------------

// File: rtl/can_param_registry.sv
// CAN acceptance-filter parameter registry: host bytes land in shadow registers,
// and a commit validates every filter before swapping the whole set in at once.

module can_filter_shadow #(
  parameter int ID_W   = 11,
  parameter int BPI    = 2,
  parameter int ADDR_W = 5,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  input  logic              en,
  output logic [ID_W-1:0]   code,
  output logic [ID_W-1:0]   mask,
  output logic              bad
);

  // One register slice per byte lane; the top lane keeps only the bits below ID_W.
  for (genvar k = 0; k < BPI; k++) begin : g_byte
    localparam int LO = 8 * k;
    localparam int W  = (ID_W - LO < 8) ? (ID_W - LO) : 8;

    logic         code_hit;
    logic         mask_hit;
    logic [W-1:0] code_b;
    logic [W-1:0] mask_b;

    assign code_hit = we && (addr == ADDR_W'(BASE + k));
    assign mask_hit = we && (addr == ADDR_W'(BASE + BPI + k));

    always_ff @(posedge clk) begin
      if (reset) begin
        code_b <= '0;
        mask_b <= '0;
      end else begin
        if (code_hit) code_b <= data[W-1:0];
        if (mask_hit) mask_b <= data[W-1:0];
      end
    end

    assign code[LO +: W] = code_b;
    assign mask[LO +: W] = mask_b;
  end

  // A code bit outside the compare mask could never match: reject it.
  assign bad = en && (|(code & ~mask));

endmodule

module can_param_registry #(
  parameter int NUM_FILTERS = 4,
  parameter int ID_W        = 11,
  parameter int ADDR_W      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [7:0]                  wr_data,
  input  logic                        commit,
  output logic                        busy,
  output logic                        commit_done,
  output logic                        cfg_err,
  output logic                        wr_err,
  output logic                        locked,
  output logic [NUM_FILTERS*ID_W-1:0] code_param,
  output logic [NUM_FILTERS*ID_W-1:0] mask_param,
  output logic [NUM_FILTERS-1:0]      filter_en,
  output logic [1:0]                  sjw
);

  localparam int BPI = (ID_W + 7) / 8;
  localparam int G   = NUM_FILTERS * 2 * BPI;
  localparam int IW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  localparam logic [ADDR_W-1:0] SJW_ADDR  = ADDR_W'(G);
  localparam logic [ADDR_W-1:0] EN_ADDR   = ADDR_W'(G + 1);
  localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(G + 2);
  localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(G + 3);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          fail;

  logic accept;
  logic drop;
  logic sh_we;

  logic [NUM_FILTERS-1:0][ID_W-1:0] sh_code;
  logic [NUM_FILTERS-1:0][ID_W-1:0] sh_mask;
  logic [NUM_FILTERS-1:0]           sh_en;
  logic [NUM_FILTERS-1:0]           bad;
  logic [1:0]                       sh_sjw;
  logic                             sh_lock;

  logic [NUM_FILTERS-1:0][ID_W-1:0] act_code;
  logic [NUM_FILTERS-1:0][ID_W-1:0] act_mask;
  logic [NUM_FILTERS-1:0]           act_en;
  logic [1:0]                       act_sjw;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = wr_valid && wr_ready;
  assign drop     = locked || ({1'b0, wr_addr} >= ADDR_LIM);
  assign sh_we    = accept && !drop;

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filt
    can_filter_shadow #(
      .ID_W   (ID_W),
      .BPI    (BPI),
      .ADDR_W (ADDR_W),
      .BASE   (f * 2 * BPI)
    ) u_shadow (
      .clk  (clk),
      .reset(reset),
      .we   (sh_we),
      .addr (wr_addr),
      .data (wr_data),
      .en   (sh_en[f]),
      .code (sh_code[f]),
      .mask (sh_mask[f]),
      .bad  (bad[f])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_sjw  <= '0;
      sh_en   <= '0;
      sh_lock <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= accept && drop;
      if (sh_we) begin
        if (wr_addr == SJW_ADDR)  sh_sjw  <= wr_data[1:0];
        if (wr_addr == EN_ADDR)   sh_en   <= wr_data[NUM_FILTERS-1:0];
        if (wr_addr == LOCK_ADDR) sh_lock <= wr_data[0];
      end
    end
  end

  // Shadow is frozen outside IDLE, so APPLY copies a consistent snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      fail        <= 1'b0;
      commit_done <= 1'b0;
      cfg_err     <= 1'b0;
      locked      <= 1'b0;
      act_code    <= '0;
      act_mask    <= '0;
      act_en      <= '0;
      act_sjw     <= '0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        IDLE: begin
          if (commit && !locked) begin
            state <= CHECK;
            idx   <= '0;
            fail  <= 1'b0;
          end
        end
        CHECK: begin
          fail <= fail | bad[idx];
          if (idx == IW'(NUM_FILTERS - 1)) state <= APPLY;
          else                             idx   <= idx + IW'(1);
        end
        APPLY: begin
          state       <= IDLE;
          commit_done <= 1'b1;
          if (fail) begin
            cfg_err <= 1'b1;
          end else begin
            act_code <= sh_code;
            act_mask <= sh_mask;
            act_en   <= sh_en;
            act_sjw  <= sh_sjw;
            locked   <= locked | sh_lock;
            cfg_err  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign code_param = act_code;
  assign mask_param = act_mask;
  assign filter_en  = act_en;
  assign sjw        = act_sjw;

endmodule

// File: tb/tb_can_param_registry.sv
// Scoreboard bench for can_param_registry: a byte-level model predicts each commit
// outcome and wr_err pulse; a monitor checks them as the DUT presents them.
module tb_can_param_registry;

  localparam int NF  = 4;
  localparam int IDW = 11;
  localparam int AW  = 5;
  localparam int BPI = 2;
  localparam int G   = NF * 2 * BPI;
  localparam int LAT = NF + 2;
  localparam logic [31:0] IDMASK = (32'd1 << IDW) - 32'd1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0;
  logic commit = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic wr_ready, busy, commit_done, cfg_err, wr_err, locked;
  logic [NF*IDW-1:0] code_param, mask_param;
  logic [NF-1:0] filter_en;
  logic [1:0] sjw;

  // second instance at ID_W=29 (2 filters so the map fits 5 address bits)
  logic r2 = 1'b1, v2 = 1'b0, c2 = 1'b0;
  logic [4:0] a2 = '0;
  logic [7:0] d2 = '0;
  logic rdy2, busy2, done2, cerr2, werr2, lock2;
  logic [57:0] code2, mask2;
  logic [1:0] en2, sjw2;

  can_param_registry #(.NUM_FILTERS(NF), .ID_W(IDW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .busy(busy),
    .commit_done(commit_done), .cfg_err(cfg_err), .wr_err(wr_err), .locked(locked),
    .code_param(code_param), .mask_param(mask_param), .filter_en(filter_en), .sjw(sjw)
  );

  can_param_registry #(.NUM_FILTERS(2), .ID_W(29), .ADDR_W(5)) dut29 (
    .clk(clk), .reset(r2), .wr_valid(v2), .wr_ready(rdy2),
    .wr_addr(a2), .wr_data(d2), .commit(c2), .busy(busy2),
    .commit_done(done2), .cfg_err(cerr2), .wr_err(werr2), .locked(lock2),
    .code_param(code2), .mask_param(mask2), .filter_en(en2), .sjw(sjw2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  typedef struct packed {
    int                cyc;
    logic [NF*IDW-1:0] code;
    logic [NF*IDW-1:0] mask;
    logic [NF-1:0]     en;
    logic [1:0]        sjw;
    logic              locked;
    logic              err;
  } exp_t;

  exp_t expq[$];
  int   errq[$];

  // reference model
  logic [31:0] m_code[NF];
  logic [31:0] m_mask[NF];
  logic [NF-1:0] m_en;
  logic [1:0] m_sjw;
  logic m_lockreq;
  logic [NF*IDW-1:0] a_code, a_mask;
  logic [NF-1:0] a_en;
  logic [1:0] a_sjw;
  logic m_locked, m_err;
  int tc = -1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_busy();
    return (cyc >= tc + 1) && (cyc <= tc + NF + 1);
  endfunction

  task automatic model_flush();
    for (int f = 0; f < NF; f++) begin
      m_code[f] = '0;
      m_mask[f] = '0;
    end
    m_en = '0; m_sjw = '0; m_lockreq = 1'b0;
    a_code = '0; a_mask = '0; a_en = '0; a_sjw = '0;
    m_locked = 1'b0; m_err = 1'b0;
    tc = -1000;
    expq.delete();
    errq.delete();
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    int f, o;
    if (m_locked || a >= G + 3) begin
      errq.push_back(cyc + 1);
      return;
    end
    if (a < G) begin
      f = a / (2 * BPI);
      o = a % (2 * BPI);
      if (o < BPI)
        m_code[f] = ((m_code[f] & ~(32'hFF << (8 * o))) | (32'(d) << (8 * o))) & IDMASK;
      else
        m_mask[f] = ((m_mask[f] & ~(32'hFF << (8 * (o - BPI)))) | (32'(d) << (8 * (o - BPI)))) & IDMASK;
    end else if (a == G)     m_sjw = d[1:0];
    else if (a == G + 1)     m_en = d[NF-1:0];
    else                     m_lockreq = d[0];
  endtask

  task automatic model_commit();
    bit ok;
    exp_t e;
    if (m_locked || exp_busy()) return;
    ok = 1'b1;
    for (int f = 0; f < NF; f++)
      if (m_en[f] && ((m_code[f] & ~m_mask[f]) != 0)) ok = 1'b0;
    if (ok) begin
      for (int f = 0; f < NF; f++) begin
        a_code[f*IDW +: IDW] = m_code[f][IDW-1:0];
        a_mask[f*IDW +: IDW] = m_mask[f][IDW-1:0];
      end
      a_en = m_en; a_sjw = m_sjw;
      m_locked = m_locked | m_lockreq;
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    e.cyc = cyc + LAT; e.code = a_code; e.mask = a_mask; e.en = a_en;
    e.sjw = a_sjw; e.locked = m_locked; e.err = m_err;
    expq.push_back(e);
    tc = cyc;
  endtask

  // one IDLE-cycle operation: optional write, optional commit, on the same edge
  task automatic op(input bit w, input int a, input logic [7:0] d, input bit c, output int waits);
    @(negedge clk);
    wr_valid = w; wr_addr = AW'(a); wr_data = d; commit = c; waits = 0;
    while (w && !wr_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      checks++; errors++;
      $display("FAIL wr_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
    end else begin
      if (w) model_write(a, d);
      if (c) model_commit();
    end
    @(negedge clk);
    wr_valid = 1'b0; commit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_flush();
    armed = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_code"}, 64'(code_param), 64'd0);
    chk({tag, "_mask"}, 64'(mask_param), 64'd0);
    chk({tag, "_en"}, 64'(filter_en), 64'd0);
    chk({tag, "_sjw"}, 64'(sjw), 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
    chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
  endtask

  // monitor: settles 2 time units after each falling edge
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (armed) begin
      chk("busy", 64'(busy), 64'(exp_busy()));
      chk("wr_ready", 64'(wr_ready), 64'(!exp_busy()));
      if (commit_done) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL commit_done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("code_param", 64'(code_param), 64'(e.code));
          chk("mask_param", 64'(mask_param), 64'(e.mask));
          chk("filter_en", 64'(filter_en), 64'(e.en));
          chk("sjw", 64'(sjw), 64'(e.sjw));
          chk("locked", 64'(locked), 64'(e.locked));
          chk("cfg_err", 64'(cfg_err), 64'(e.err));
        end
      end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        checks++; errors++;
        $display("FAIL commit_done_missing: got 0 expected 1 at cycle %0d", e.cyc);
      end
      if (wr_err) begin
        if (errq.size() != 0 && errq[0] == cyc) begin
          void'(errq.pop_front());
          checks++;
        end else begin
          checks++; errors++;
          $display("FAIL wr_err_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end
      end else if (errq.size() != 0 && errq[0] <= cyc) begin
        void'(errq.pop_front());
        checks++; errors++;
        $display("FAIL wr_err_missing: got 0 expected 1 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    int w;
    int a;
    logic [7:0] d;
    model_flush();

    do_reset();
    @(negedge clk);
    check_zero("reset");

    // basic load of filter0 and sjw
    op(1, 0, 8'h23, 0, w); op(1, 1, 8'h01, 0, w);
    op(1, 2, 8'hFF, 0, w); op(1, 3, 8'h07, 0, w);
    op(1, G + 1, 8'h01, 0, w); op(1, G, 8'h02, 0, w);
    op(0, 0, 8'h00, 1, w);
    repeat (LAT + 1) @(negedge clk);
    chk("t1_code0", 64'(code_param[10:0]), 64'h123);
    chk("t1_mask0", 64'(mask_param[10:0]), 64'h7FF);
    chk("t1_en", 64'(filter_en), 64'h1);
    chk("t1_sjw", 64'(sjw), 64'h2);

    // invalid filter2 rejects the whole commit
    op(1, 8, 8'hF0, 0, w); op(1, 9, 8'h00, 0, w);
    op(1, 10, 8'h0F, 0, w); op(1, 11, 8'h00, 0, w);
    op(1, G + 1, 8'h05, 0, w);
    op(0, 0, 8'h00, 1, w);
    repeat (LAT + 1) @(negedge clk);
    chk("t2_cfg_err", 64'(cfg_err), 64'h1);
    chk("t2_code0", 64'(code_param[10:0]), 64'h123);
    chk("t2_code2", 64'(code_param[32:22]), 64'h0);
    chk("t2_en", 64'(filter_en), 64'h1);

    // repaired mask applies
    op(1, 10, 8'hFF, 0, w);
    op(0, 0, 8'h00, 1, w);
    repeat (LAT + 1) @(negedge clk);
    chk("t3_cfg_err", 64'(cfg_err), 64'h0);
    chk("t3_code2", 64'(code_param[32:22]), 64'h0F0);
    chk("t3_mask2", 64'(mask_param[32:22]), 64'h0FF);
    chk("t3_en", 64'(filter_en), 64'h5);

    // out-of-range write
    op(1, G + 3, 8'hAA, 0, w);
    repeat (2) @(negedge clk);
    chk("t4_sjw", 64'(sjw), 64'h2);

    // write held across a commit waits for IDLE
    op(0, 0, 8'h00, 1, w);
    op(1, 1, 8'h02, 0, w);
    chk("t5_wait_cycles", 64'(w), 64'(NF));
    op(0, 0, 8'h00, 1, w);
    repeat (LAT + 1) @(negedge clk);
    chk("t5_code0", 64'(code_param[10:0]), 64'h223);

    // lock
    op(1, G + 2, 8'h01, 0, w);
    op(0, 0, 8'h00, 1, w);
    repeat (LAT + 1) @(negedge clk);
    chk("t6_locked", 64'(locked), 64'h1);
    op(1, 0, 8'h55, 0, w);
    op(0, 0, 8'h00, 1, w);
    repeat (LAT + 2) @(negedge clk);
    chk("t6_code0_kept", 64'(code_param[10:0]), 64'h223);
    do_reset();
    @(negedge clk);
    check_zero("t6_reset");

    // reset two cycles after commit aborts it
    op(1, 0, 8'h11, 0, w); op(1, 2, 8'hFF, 0, w); op(1, G + 1, 8'h01, 0, w);
    op(0, 0, 8'h00, 1, w);
    do_reset();
    repeat (LAT + 1) @(negedge clk);
    check_zero("t7_abort");

    // randomized writes and commits
    for (int i = 0; i < 80; i++) begin
      a = int'($urandom_range(0, G + 3));
      d = 8'($urandom);
      if (a < G && (a % (2 * BPI)) >= BPI && $urandom_range(0, 1) == 1) d = 8'hFF;
      if (a < G && (a % (2 * BPI)) < BPI && $urandom_range(0, 2) == 0) d = 8'h00;
      if (a == G + 2) d[0] = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        op($urandom_range(0, 1) == 1, a, d, 1, w);
        repeat (NF + 2) @(negedge clk);
      end else begin
        op(1, a, d, 0, w);
      end
    end
    repeat (LAT + 2) @(negedge clk);
    chk("queue_commit_empty", 64'(expq.size()), 64'd0);
    chk("queue_wrerr_empty", 64'(errq.size()), 64'd0);

    // ID_W=29 instance: four 0xFF code bytes give a 29-bit all-ones code
    @(negedge clk); r2 = 1'b1;
    @(negedge clk); r2 = 1'b0;
    chk("w29_reset_code", 64'(code2), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); v2 = 1'b1; a2 = 5'(k); d2 = 8'hFF;
    end
    @(negedge clk); a2 = 5'd17; d2 = 8'h01;
    @(negedge clk); v2 = 1'b0; c2 = 1'b1;
    @(negedge clk); c2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("w29_code0", 64'(code2[28:0]), 64'h1FFFFFFF);
    chk("w29_code1", 64'(code2[57:29]), 64'h0);
    chk("w29_mask0", 64'(mask2[28:0]), 64'h1FFFFFFF);
    chk("w29_en", 64'(en2), 64'h1);
    chk("w29_cfg_err", 64'(cerr2), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
